// File: rtl/sram_req_seq_if.sv
// Cache-side request/response channel and SRAM port of the request sequencer.
// Handshake: a transfer happens on a posedge where valid && ready are both 1; valid must not wait on ready.
interface sram_req_seq_if #(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3
);
  logic                     reqValid;
  logic                     reqReady;
  logic                     reqWrite;
  logic [logDepth-1:0]      reqAddr;
  logic [logLineOffset-1:0] reqOffset;
  logic [width-1:0]         reqData;
  logic                     respValid;
  logic                     respReady;
  logic [width-1:0]         respData;
  logic                     writeDone;
  logic [logDepth-1:0]      sramReadAddr;
  logic [width-1:0]         sramReadData;
  logic [logDepth-1:0]      sramWriteAddr;
  logic [logLineOffset-1:0] sramWriteOffset;
  logic [width-1:0]         sramWriteData;
  logic                     sramWriteEnable;
  logic                     sramWriteConfirm;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqOffset, reqData, respReady, sramReadData,
    output reqReady, respValid, respData, writeDone, sramReadAddr,
           sramWriteAddr, sramWriteOffset, sramWriteData, sramWriteEnable, sramWriteConfirm
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqOffset, reqData, respReady, sramReadData,
    input  reqReady, respValid, respData, writeDone, sramReadAddr,
           sramWriteAddr, sramWriteOffset, sramWriteData, sramWriteEnable, sramWriteConfirm
  );
endinterface

// File: rtl/sram_req_seq.sv
// Single-outstanding request sequencer between a cache and a fixed-latency SRAM.
// Reads wait readLat edges for SRAM data; writes take one strobe cycle.
module sram_req_seq #(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3,
  parameter int readLat       = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  sram_req_seq_if.slave     bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_RESP = 2'd2,
    WRITE     = 2'd3
  } state_t;

  if (readLat < 1 || readLat > 15) begin : g_bad_read_lat
    $fatal(1, "sram_req_seq: readLat=%0d outside legal range 1..15", readLat);
  end

  localparam logic [3:0] LoadCnt = 4'(readLat - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [3:0]               r_cnt;
  logic [logDepth-1:0]      r_addr;
  logic [logLineOffset-1:0] r_offset;
  logic [width-1:0]         r_data;
  logic [width-1:0]         r_resp;
  logic                     w_accept;
  logic                     w_capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Write strobes decode straight from the state so reset drops them without waiting for an edge.
  always_comb begin
    w_next               = r_state;
    w_accept             = 1'b0;
    w_capture            = 1'b0;
    bus.reqReady         = 1'b0;
    bus.respValid        = 1'b0;
    bus.writeDone        = 1'b0;
    bus.sramWriteEnable  = 1'b0;
    bus.sramWriteConfirm = 1'b0;
    case (r_state)
      IDLE: begin
        bus.reqReady = 1'b1;
        if (bus.reqValid) begin
          w_accept = 1'b1;
          w_next   = bus.reqWrite ? WRITE : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = READ_RESP;
        end
      end
      READ_RESP: begin
        bus.respValid = 1'b1;
        if (bus.respReady) w_next = IDLE;
      end
      WRITE: begin
        bus.sramWriteEnable  = 1'b1;
        bus.sramWriteConfirm = 1'b1;
        bus.writeDone        = 1'b1;
        w_next               = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_offset <= '0;
      r_data   <= '0;
      r_resp   <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= LoadCnt;
        r_addr   <= bus.reqAddr;
        r_offset <= bus.reqOffset;
        r_data   <= bus.reqData;
      end else if (r_state == READ_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) r_resp <= bus.sramReadData;
    end
  end

  // Address registers only move on accept, so the read index holds through IDLE.
  assign bus.respData        = r_resp;
  assign bus.sramReadAddr    = r_addr;
  assign bus.sramWriteAddr   = r_addr;
  assign bus.sramWriteOffset = r_offset;
  assign bus.sramWriteData   = r_data;
  assign o_dbg_state         = r_state;

endmodule

// File: doc/sram_req_seq.md
SRAM_REQ_SEQ -- requirements
Module: sram_req_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- width, 16, SRAM line width in bits.
- logDepth, 9, log2 of SRAM line count.
- logLineOffset, 3, log2 of words per line.
- readLat, 2, edges from read accept to captured data; legal range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on posedge.
- reset_n, in, 1, asynchronous active-low reset.
- reqValid, in, 1, cache request present.
- reqReady, out, 1, sequencer can accept a request.
- reqWrite, in, 1, 1=write, 0=read.
- reqAddr, in, logDepth, line index.
- reqOffset, in, logLineOffset, word offset for writes.
- reqData, in, width, write line; only the word at reqOffset is meaningful.
- respValid, out, 1, read data valid.
- respReady, in, 1, cache consumes read data.
- respData, out, width, read line.
- writeDone, out, 1, one-cycle write completion pulse.
- sramReadAddr, out, logDepth, SRAM read index.
- sramReadData, in, width, SRAM read line.
- sramWriteAddr, out, logDepth, SRAM write index.
- sramWriteOffset, out, logLineOffset, SRAM write word offset.
- sramWriteData, out, width, SRAM write line.
- sramWriteEnable, out, 1, SRAM write strobe.
- sramWriteConfirm, out, 1, SRAM write-go qualifier.

Function
REQ-003 Exactly one request SHALL be outstanding at a time; states: IDLE, READ_WAIT, READ_RESP, WRITE.
REQ-004 reqReady SHALL be 1 only in IDLE; a request is accepted on an edge where reqValid && reqReady.
REQ-005 On accept: latch reqAddr, reqOffset, reqData; go to READ_WAIT if reqWrite=0, else WRITE.
REQ-006 READ_WAIT: sramReadAddr SHALL hold the latched address; a 4-bit counter loads readLat-1 on accept and decrements each edge.
REQ-007 On the edge where the READ_WAIT counter is 0, respData SHALL capture sramReadData and the FSM SHALL enter READ_RESP; respValid therefore rises exactly readLat edges after accept.
REQ-008 READ_RESP: respValid=1 and respData SHALL be held stable until an edge with respReady=1, then go to IDLE.
REQ-009 respReady SHALL be ignored outside READ_RESP.
REQ-010 WRITE lasts exactly one cycle: sramWriteEnable=1, sramWriteConfirm=1, writeDone=1, sramWriteAddr/Offset/Data = latched values; next state IDLE.
REQ-011 sramWriteEnable, sramWriteConfirm and writeDone SHALL be 0 in every state other than WRITE.
REQ-012 Back-to-back: a new request SHALL be acceptable on the first IDLE cycle after READ_RESP or WRITE; minimum spacing is readLat+2 edges for reads and 2 edges for writes.
REQ-013 A request presented while reqReady=0 SHALL NOT be latched and SHALL NOT disturb the transaction in flight.
REQ-014 sramReadAddr in IDLE SHALL hold its last value.
REQ-015 A readLat outside 1..15 SHALL produce a $fatal at elaboration or time 0.

Reset
REQ-016 While reset_n=0: state IDLE, reqReady=1, respValid=0, writeDone=0, sramWriteEnable=0, sramWriteConfirm=0, respData=0, all SRAM address, offset and data outputs 0, counter 0.
REQ-017 Reset asserted mid-READ_WAIT or mid-READ_RESP SHALL drop the transaction without a response; reset asserted in WRITE SHALL deassert the write strobes immediately (asynchronously).
REQ-018 The first accept SHALL be possible on the first posedge after reset_n rises.

Verification
REQ-019 Reset release, then read addr 5 with readLat=2 and SRAM returning 0xBEEF -> respValid rises exactly 2 edges after accept, respData=0xBEEF, sramReadAddr=5 throughout.
REQ-020 Write addr 3, offset 2, data 0x00F0 -> exactly one cycle with sramWriteEnable=sramWriteConfirm=writeDone=1 and addr 3, offset 2; reqReady=1 on the next cycle.
REQ-021 Read completes with respReady held 0 for 5 cycles -> respValid and respData stable all 5 cycles, reqReady=0; respReady=1 -> IDLE on the next edge.
REQ-022 Second request driven during READ_WAIT with a different address -> ignored; the first response carries the first address's data.
REQ-023 reset_n pulsed low in READ_WAIT -> no respValid; all outputs at reset values; a fresh read after release completes normally.
REQ-024 Alternate write then read to the same address at maximum rate (readLat=1) -> write strobe cycle, then read accept on the next IDLE, respValid 1 edge later.
